// File: rtl/place_sched.sv
// Placement scheduler: accepts a program footprint, walks a short list of
// candidate placement structures for that height, allocates the first free
// one and reports the result. Structures are freed by an independent release
// strobe that is honoured in every state.
module place_sched #(
  parameter int NUM_STR = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         height_in,
  input  logic [4:0]         width_in,
  input  logic [3:0]         prog_id,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_ok,
  output logic [3:0]         resp_str_id,
  output logic [3:0]         resp_prog_id,
  input  logic               rel_valid,
  input  logic [3:0]         rel_str_id,
  output logic [NUM_STR-1:0] occ,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_CHECK  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // One-hot occupancy mask for a structure ID; IDs 0 and >NUM_STR map to 0,
  // which the CHECK walk treats as "end of list" and release treats as no-op.
  function automatic logic [NUM_STR-1:0] id_mask(input logic [3:0] id);
    logic [NUM_STR-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STR; i++) begin
      if (32'(id) == 32'(i + 1)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Candidate list {c0,c1,c2} for a program footprint; 0 terminates the list.
  function automatic logic [11:0] lookup_cands(input logic [4:0] h, input logic [4:0] w);
    logic [11:0] c;
    if ((w == 5'd0) || (w > 5'd16)) begin
      c = 12'h000;
    end else begin
      case (h)
        5'd4:    c = {4'd8,  4'd10, 4'd0};
        5'd5:    c = {4'd6,  4'd8,  4'd0};
        5'd6:    c = {4'd4,  4'd6,  4'd0};
        5'd7:    c = {4'd1,  4'd2,  4'd4};
        5'd8:    c = {4'd1,  4'd2,  4'd3};
        5'd9:    c = {4'd3,  4'd5,  4'd0};
        5'd10:   c = {4'd5,  4'd7,  4'd0};
        5'd11:   c = {4'd7,  4'd9,  4'd0};
        5'd12:   c = {4'd9,  4'd0,  4'd0};
        5'd13, 5'd14, 5'd15, 5'd16:
                 c = {4'd11, 4'd12, 4'd13};
        default: c = 12'h000;
      endcase
    end
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [4:0]         h_q, h_d;
  logic [4:0]         w_q, w_d;
  logic [3:0]         pid_q, pid_d;
  logic [3:0]         c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic [1:0]         k_q, k_d;
  logic [NUM_STR-1:0] occ_q, occ_d;
  logic               dec_ok_q, dec_ok_d;
  logic [3:0]         dec_str_q, dec_str_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_ok_q, resp_ok_d;
  logic [3:0]         resp_str_q, resp_str_d;
  logic [3:0]         resp_prog_q, resp_prog_d;

  logic [3:0]         cur_id;
  logic [NUM_STR-1:0] cur_mask;
  logic [NUM_STR-1:0] alloc_mask;
  logic [NUM_STR-1:0] rel_mask;

  // Next-state, candidate walk, response staging and occupancy update.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    w_d          = w_q;
    pid_d        = pid_q;
    c0_d         = c0_q;
    c1_d         = c1_q;
    c2_d         = c2_q;
    k_d          = k_q;
    dec_ok_d     = dec_ok_q;
    dec_str_d    = dec_str_q;
    resp_valid_d = resp_valid_q;
    resp_ok_d    = resp_ok_q;
    resp_str_d   = resp_str_q;
    resp_prog_d  = resp_prog_q;
    alloc_mask   = '0;

    case (k_q)
      2'd0:    cur_id = c0_q;
      2'd1:    cur_id = c1_q;
      2'd2:    cur_id = c2_q;
      default: cur_id = 4'd0;
    endcase
    cur_mask = id_mask(cur_id);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          h_d     = height_in;
          w_d     = width_in;
          pid_d   = prog_id;
          state_d = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        {c0_d, c1_d, c2_d} = lookup_cands(h_q, w_q);
        k_d                = 2'd0;
        state_d            = S_CHECK;
      end
      S_CHECK: begin
        // Decision uses the registered map, so a same-cycle release of this
        // candidate is not seen until the following cycle.
        if (cur_mask == '0) begin
          dec_ok_d  = 1'b0;
          dec_str_d = 4'd0;
          state_d   = S_RESP;
        end else if ((occ_q & cur_mask) == '0) begin
          alloc_mask = cur_mask;
          dec_ok_d   = 1'b1;
          dec_str_d  = cur_id;
          state_d    = S_RESP;
        end else if (k_q == 2'd2) begin
          dec_ok_d  = 1'b0;
          dec_str_d = 4'd0;
          state_d   = S_RESP;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_RESP: begin
        // First RESP cycle loads the output registers; they then hold until
        // the consumer takes the result.
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_ok_d    = dec_ok_q;
          resp_str_d   = dec_str_q;
          resp_prog_d  = pid_q;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_ok_d    = 1'b0;
          resp_str_d   = 4'd0;
          resp_prog_d  = 4'd0;
          dec_ok_d     = 1'b0;
          dec_str_d    = 4'd0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (rel_valid) begin
      rel_mask = id_mask(rel_str_id);
    end else begin
      rel_mask = '0;
    end
    occ_d = (occ_q & ~rel_mask) | alloc_mask;
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      h_q          <= 5'd0;
      w_q          <= 5'd0;
      pid_q        <= 4'd0;
      c0_q         <= 4'd0;
      c1_q         <= 4'd0;
      c2_q         <= 4'd0;
      k_q          <= 2'd0;
      occ_q        <= '0;
      dec_ok_q     <= 1'b0;
      dec_str_q    <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_str_q   <= 4'd0;
      resp_prog_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      w_q          <= w_d;
      pid_q        <= pid_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      c2_q         <= c2_d;
      k_q          <= k_d;
      occ_q        <= occ_d;
      dec_ok_q     <= dec_ok_d;
      dec_str_q    <= dec_str_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      resp_str_q   <= resp_str_d;
      resp_prog_q  <= resp_prog_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_ok      = resp_ok_q;
  assign resp_str_id  = resp_str_q;
  assign resp_prog_id = resp_prog_q;
  assign occ          = occ_q;

endmodule

// File: tb/tb_place_sched.sv
// Self-checking bench for place_sched: directed scenarios followed by random
// requests and releases, checked against a table-driven allocation model.
module tb_place_sched;

  localparam int NUM_STR = 13;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [4:0]         height_in;
  logic [4:0]         width_in;
  logic [3:0]         prog_id;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_ok;
  logic [3:0]         resp_str_id;
  logic [3:0]         resp_prog_id;
  logic               rel_valid;
  logic [3:0]         rel_str_id;
  logic [NUM_STR-1:0] occ;
  logic               busy;

  int n_assert;
  int n_fail;
  logic [NUM_STR-1:0] occ_m;

  place_sched #(.NUM_STR(NUM_STR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .height_in(height_in), .width_in(width_in), .prog_id(prog_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_ok(resp_ok), .resp_str_id(resp_str_id), .resp_prog_id(resp_prog_id),
    .rel_valid(rel_valid), .rel_str_id(rel_str_id),
    .occ(occ), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Candidate table straight from the placement rules.
  function automatic int cand_of(input int h, input int w, input int idx);
    int t[3];
    t = '{0, 0, 0};
    if (w >= 1 && w <= 16) begin
      case (h)
        4:  t = '{8, 10, 0};
        5:  t = '{6, 8, 0};
        6:  t = '{4, 6, 0};
        7:  t = '{1, 2, 4};
        8:  t = '{1, 2, 3};
        9:  t = '{3, 5, 0};
        10: t = '{5, 7, 0};
        11: t = '{7, 9, 0};
        12: t = '{9, 0, 0};
        13, 14, 15, 16: t = '{11, 12, 13};
        default: t = '{0, 0, 0};
      endcase
    end
    return t[idx];
  endfunction

  // First free candidate wins; latency is 3 edges plus one per extra candidate.
  task automatic predict(input int h, input int w, output int ok, output int str, output int lat);
    int c;
    ok = 0; str = 0; lat = 5;
    for (int idx = 0; idx < 3; idx++) begin
      c = cand_of(h, w, idx);
      if (c == 0) begin
        lat = 3 + idx;
        break;
      end
      if (!occ_m[c-1]) begin
        ok = 1; str = c; lat = 3 + idx;
        occ_m[c-1] = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_rel(input int id);
    if (id >= 1 && id <= NUM_STR) occ_m[id-1] = 1'b0;
  endtask

  task automatic do_rel(input int id);
    rel_valid = 1'b1; rel_str_id = 4'(id);
    @(posedge clk); #1;
    rel_valid = 1'b0;
    model_rel(id);
    chk("occ_after_release", 32'(occ), 32'(occ_m));
  endtask

  // One request: optional release pulse after edge E0+rel_when, optional hold
  // of resp_ready low for 'hold' cycles with a release inside the hold.
  task automatic do_req(input int h, input int w, input int pid, input int hold,
                        input int hold_rel, input int rel_when, input int rel_id);
    int ok_e, str_e, lat_e, edges;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    predict(h, w, ok_e, str_e, lat_e);
    height_in = 5'(h); width_in = 5'(w); prog_id = 4'(pid); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (rel_when == 0) begin rel_valid = 1'b1; rel_str_id = 4'(rel_id); end
    while (resp_valid !== 1'b1 && edges < 12) begin
      @(posedge clk); #1;
      edges++;
      if (rel_valid) begin rel_valid = 1'b0; model_rel(int'(rel_str_id)); end
      if (edges == rel_when) begin rel_valid = 1'b1; rel_str_id = 4'(rel_id); end
    end
    chk("resp_latency", 32'(edges), 32'(lat_e));
    chk("resp_ok", 32'(resp_ok), 32'(ok_e));
    chk("resp_str_id", 32'(resp_str_id), 32'(str_e));
    chk("resp_prog_id", 32'(resp_prog_id), 32'(pid));
    chk("occ_at_resp", 32'(occ), 32'(occ_m));
    for (int i = 0; i < hold; i++) begin
      if (i == 1 && hold_rel >= 0) begin rel_valid = 1'b1; rel_str_id = 4'(hold_rel); end
      @(posedge clk); #1;
      if (rel_valid) begin rel_valid = 1'b0; model_rel(int'(rel_str_id)); end
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_ok", 32'(resp_ok), 32'(ok_e));
      chk("hold_str", 32'(resp_str_id), 32'(str_e));
      chk("hold_prog", 32'(resp_prog_id), 32'(pid));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_occ", 32'(occ), 32'(occ_m));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_ok", 32'(resp_ok), 32'd0);
    chk("post_str", 32'(resp_str_id), 32'd0);
    chk("post_prog", 32'(resp_prog_id), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int h, w, hold, hrel;
    n_assert = 0; n_fail = 0; occ_m = '0;
    rst = 1'b1; req_valid = 1'b0; height_in = 5'd0; width_in = 5'd0; prog_id = 4'd0;
    resp_ready = 1'b0; rel_valid = 1'b0; rel_str_id = 4'd0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_ok", 32'(resp_ok), 32'd0);
    chk("rst_resp_str", 32'(resp_str_id), 32'd0);
    chk("rst_resp_prog", 32'(resp_prog_id), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // First allocation: structure 1 after three edges
    do_req(8, 4, 3, 0, -1, -1, 0);
    chk("occ_first_alloc", 32'(occ), 32'h0001);
    // Height 7 walks 1 (busy) -> 2, then 1,2 busy -> 4 at the last slot
    do_req(7, 5, 6, 0, -1, -1, 0);
    do_req(7, 5, 7, 0, -1, -1, 0);
    chk("occ_after_h7", 32'(occ), 32'h000B);
    // Height 12: take 9, then reject with 9 busy
    do_req(12, 8, 1, 0, -1, -1, 0);
    do_req(12, 8, 2, 0, -1, -1, 0);
    chk("occ_after_h12_reject", 32'(occ), 32'h010B);
    // Unsupported height and out-of-range widths
    do_req(3, 4, 9, 0, -1, -1, 0);
    do_req(8, 0, 10, 0, -1, -1, 0);
    do_req(8, 20, 11, 0, -1, -1, 0);
    // Consumer stalls five cycles while structure 1 is released
    do_req(8, 4, 12, 5, 1, -1, 0);
    chk("occ_after_hold_release", 32'(occ), 32'h010E);
    // Release of 3 coincides with CHECK of 3: old map used, falls through to 5
    do_req(9, 4, 13, 0, -1, 1, 3);
    // Release of 9 coincides with allocation of 8: both land
    do_req(4, 4, 14, 0, -1, 1, 9);
    chk("occ_after_concurrent", 32'(occ), 32'h009A);
    // Ignored and no-op releases
    do_rel(0);
    do_rel(14);
    do_rel(15);
    do_rel(1);

    // Reset while in CHECK aborts the request and frees everything
    height_in = 5'd7; width_in = 5'd4; prog_id = 4'd5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_occ", 32'(occ), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    occ_m = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    end

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1) do_rel(int'($urandom_range(0, 15)));
      h    = int'($urandom_range(2, 18));
      w    = int'($urandom_range(0, 18));
      hold = int'($urandom_range(0, 3));
      hrel = (hold >= 2) ? int'($urandom_range(0, 15)) : -1;
      do_req(h, w, int'($urandom_range(0, 15)), hold, hrel, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
